undistort: RTL and testbench
============================

# undistort

Streaming inverse of the audio distortion stage. It takes distorted 8-bit samples and regenerates the same pseudo-random offset sequence as the distorter, using an identical LFSR and seed. It then removes each offset exactly, with modulo-256 arithmetic, so the original sample is recovered bit-for-bit. It sits between the distortion stage output and the audio sink, with valid/ready handshakes on both sides.

## Interface
- `LFSR_SEED`, default 16'hACE1: LFSR value after reset; also used when a zero seed is loaded.
- `I_MOD`, default 10: modulus for the direction selector i.
- `I_THRESH`, default 5: if i <= I_THRESH, the distorter added j; otherwise it subtracted j.
- `J_MOD`, default 5: modulus for the magnitude j, so j ranges 0..J_MOD-1.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `seed_load`, in, 1: one-cycle pulse that reloads the LFSR from `seed` and flushes the output.
- `seed`, in, 16: new LFSR value; 0 is replaced by LFSR_SEED.
- `in_valid`, in, 1: distorted sample is present on `in_sample`.
- `in_ready`, out, 1: block accepts a sample this cycle.
- `in_sample`, in, 8: distorted sample, unsigned.
- `out_valid`, out, 1: restored sample is present on `out_sample`.
- `out_ready`, in, 1: downstream accepts the sample.
- `out_sample`, out, 8: restored sample, unsigned.
- `sample_count`, out, 16: number of accepted samples since reset or seed load; wraps at 2^16.

## Operation
- LFSR: 16-bit Galois, shift right. If bit 0 is 1, next = (s>>1)^16'hB400; otherwise next = s>>1.
  - The LFSR advances exactly once per accepted sample (`in_valid && in_ready`).
  - The current state s, before advancing, is the one applied to that sample.
- Offset derivation from s:
  - i = s[7:0] % I_MOD
  - j = s[15:8] % J_MOD
- Restoration:
  - If i <= I_THRESH, `out_sample` = in_sample − j, mod 256.
  - Otherwise, `out_sample` = in_sample + j, mod 256.
  - There is no saturation; wrap-around is required so the inverse is exact.
- FSM states:
  - **EMPTY**: `out_valid`=0. An accepted sample moves the block to FULL.
  - **FULL**: `out_valid`=1. If the output is consumed and no new sample is accepted, move to EMPTY. If the output is consumed and a new sample is accepted in the same cycle, stay in FULL with the new data.
  - From either state, `seed_load` moves to EMPTY.
- `in_ready` = (state==EMPTY) || out_ready, and is forced to 0 in any cycle where `seed_load` or `rst` is high.
- `seed_load` priority:
  - Overrides any accept in the same cycle; the sample is not taken and the LFSR does not advance.
  - Clears `out_valid` and the held sample is discarded.
  - Sets `sample_count` to 0.
- `rst` overrides `seed_load` and everything else.
- While `out_valid`=1 and `out_ready`=0, `out_sample` is held stable.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `out_sample`=8'h00, `sample_count`=0, LFSR=LFSR_SEED.
- `in_ready`=0 during the reset cycle and 1 in the first cycle after reset.
- Latency: 1 cycle. A sample accepted at edge N appears on `out_sample` with `out_valid`=1 after edge N.
- Throughput: 1 sample per cycle while `out_ready`=1.
- Backpressure: `in_ready` falls combinationally with `out_ready` when state is FULL. No sample is dropped or duplicated.
- Reset mid-stream: the held sample is lost. The sequence restarts from LFSR_SEED, and the distorter must be reset in the same cycle.
- The modulo results are combinational from LFSR state; there is no added pipeline stage.

## Structure
- Shared package `distort_pkg`, used by both distortion and undistortion:
  - LFSR taps 16'hB400
  - default seed 16'hACE1
  - I_MOD, I_THRESH and J_MOD defaults
- Sub-module `lfsr16`, with ports `clk`, `rst`, `load`, `load_val`, `advance`, `state`. The distorter instantiates the same module so the two sequences match by construction.
- Top level contains the two-state FSM, offset arithmetic, output register and counter.

## Test plan
- Reset, then send `in_sample`=8'h64 with `out_ready`=1. With s=16'hACE1: i=5, j=2, so `out_sample`=8'h62 one cycle later and LFSR becomes 16'hE270.
- Second sample `in_sample`=8'h00, with s=16'hE270: i=2, j=1, so `out_sample`=8'hFF (subtract wrap). `sample_count`=2.
- Loopback: a distortion model feeds 1000 random samples through undistort with random `out_ready` stalls. Output must equal the original stream exactly and in order, with `sample_count`=1000.
- Hold `out_ready`=0 for 5 cycles while FULL. Required: `in_ready`=0, `out_sample` stable, and LFSR not advanced.
- Pulse `seed_load` with `seed`=0 together with `in_valid`=1. Required: sample not accepted, `out_valid`=0, LFSR=16'hACE1, `sample_count`=0.
- Assert `rst` while FULL with `out_ready`=0. Required: `out_valid`=0 next cycle and the first post-reset output repeats the first test's result.

Source files
------------

// File: rtl/distort_pkg.sv
// ============================================================================
// Module      : distort_pkg
// Description : Constants and LFSR step shared by the distort/undistort pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package distort_pkg;

  localparam logic [15:0] c_lfsr_taps    = 16'hB400;
  localparam logic [15:0] c_default_seed = 16'hACE1;
  localparam int unsigned c_i_mod        = 10;
  localparam int unsigned c_i_thresh     = 5;
  localparam int unsigned c_j_mod        = 5;

  localparam logic [0:0] c_st_empty = 1'b0;
  localparam logic [0:0] c_st_full  = 1'b1;

  // Galois right-shift step; both ends of the link must use this same step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ c_lfsr_taps) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Galois LFSR with load and advance; zero load -> SEED.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
  import distort_pkg::*;
#(
  parameter logic [15:0] SEED = c_default_seed
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] r_state;

  // An all-zero state would lock up the LFSR, so a zero load falls back to SEED.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (load) begin
      r_state <= (load_val == 16'h0000) ? SEED : load_val;
    end else if (advance) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: rtl/undistort.sv
// ============================================================================
// Module      : undistort
// Description : Removes the LFSR-driven sample offsets added by the distorter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module undistort
  import distort_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = c_default_seed,
  parameter int unsigned I_MOD     = c_i_mod,
  parameter int unsigned I_THRESH  = c_i_thresh,
  parameter int unsigned J_MOD     = c_j_mod
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_sample,
  output logic [15:0] sample_count
);

  localparam logic [7:0] c_thresh8 = 8'(I_THRESH);

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [15:0] w_lfsr_state;
  logic        w_accept;
  logic        w_consume;
  logic [7:0]  w_i;
  logic [7:0]  w_j;
  logic [7:0]  w_restored;
  logic [7:0]  r_out;
  logic [15:0] r_count;

  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  lfsr16 #(
    .SEED     (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed),
    .advance  (w_accept),
    .state    (w_lfsr_state)
  );

  // Offsets come straight from the current state; the state advances on accept.
  assign w_i = 8'(32'(w_lfsr_state[7:0]) % I_MOD);
  assign w_j = 8'(32'(w_lfsr_state[15:8]) % J_MOD);

  // The distorter added j when i <= threshold, so undo it in 8-bit wrap arithmetic.
  assign w_restored = (w_i <= c_thresh8) ? (in_sample - w_j) : (in_sample + w_j);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_empty;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (seed_load) begin
      w_state_next = c_st_empty;
    end else begin
      case (r_state)
        c_st_empty: begin
          if (w_accept) begin
            w_state_next = c_st_full;
          end
        end
        c_st_full: begin
          if (w_consume && !w_accept) begin
            w_state_next = c_st_empty;
          end
        end
        default: w_state_next = c_st_empty;
      endcase
    end
  end

  // in_ready is masked during reset and seed load so no sample slips in.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_valid = (r_state == c_st_full);
    in_ready  = !rst && !seed_load && ((r_state == c_st_empty) || out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      r_out <= 8'h00;
    end else if (w_accept) begin
      r_out <= w_restored;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      r_count <= 16'h0000;
    end else if (w_accept) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign out_sample   = r_out;
  assign sample_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_undistort.sv
// ============================================================================
// Module      : tb_undistort
// Description : Scoreboard bench for undistort with a distorter reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_undistort;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_sample;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_sample;
  logic [15:0] sample_count;

  logic [7:0]  tb_exp;
  logic        stall_en;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [7:0]  q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  undistort dut (
    .clk          (clk),
    .rst          (rst),
    .seed_load    (seed_load),
    .seed         (seed),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sample    (in_sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sample   (out_sample),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] s);
    logic [15:0] t;
    t = {1'b0, s[15:1]};
    if (s[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  // Reference distorter driven by the bench's own LFSR copy.
  function automatic logic [7:0] distort(input logic [7:0] orig);
    int i, j;
    i = int'(m_lfsr[7:0]) % 10;
    j = int'(m_lfsr[15:8]) % 5;
    return (i <= 5) ? 8'(int'(orig) + j) : 8'(int'(orig) - j);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_lfsr <= 16'hACE1;
    end else if (seed_load) begin
      q.delete();
      m_lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("sb_underflow", {31'd0, out_valid}, 32'd0);
        else check("out_sample", {24'd0, out_sample}, {24'd0, q.pop_front()});
      end
      if (in_valid && in_ready) begin
        q.push_back(tb_exp);
        m_lfsr <= m_next(m_lfsr);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_raw(input logic [7:0] smp, input logic [7:0] exp);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_sample = smp;
    tb_exp = exp;
    @(negedge clk);
    while (!in_ready && k < 500) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_orig(input logic [7:0] orig);
    send_raw(distort(orig), orig);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 2000) begin
      k++;
      @(negedge clk);
    end
    check("drain", q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = 16'h0000;
    in_valid = 1'b0; in_sample = 8'h00; out_ready = 1'b0;
    stall_en = 1'b0; tb_exp = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sample", {24'd0, out_sample}, 32'h00);
    check("rst_count", {16'd0, sample_count}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_lfsr", {16'd0, dut.w_lfsr_state}, 32'hACE1);

    // Directed: known offsets from the default seed, including subtract wrap.
    @(posedge clk); #1;
    send_raw(8'h64, 8'h62);
    check("first_latency_valid", {31'd0, out_valid}, 32'd1);
    check("first_latency_data", {24'd0, out_sample}, 32'h62);
    send_raw(8'h00, 8'hFF);
    @(negedge clk);
    check("second_data", {24'd0, out_sample}, 32'hFF);
    check("count_two", {16'd0, sample_count}, 32'd2);
    check("lfsr_two", {16'd0, dut.w_lfsr_state}, 32'h7138);

    // Backpressure: held output, no accept, LFSR frozen.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_orig(8'hA5);
    in_valid = 1'b1; in_sample = distort(8'h3C); tb_exp = 8'h3C;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_sample", {24'd0, out_sample}, 32'hA5);
      check("stall_lfsr", {16'd0, dut.w_lfsr_state}, {16'd0, m_lfsr});
      check("stall_count", {16'd0, sample_count}, 32'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_orig(8'h3C);
    drain();

    // Zero seed load while FULL with a competing sample.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_orig(8'h11);
    seed_load = 1'b1; seed = 16'h0000;
    in_valid = 1'b1; in_sample = 8'h77; tb_exp = 8'h77;
    @(negedge clk);
    check("seed_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    seed_load = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("seed_out_valid", {31'd0, out_valid}, 32'd0);
    check("seed_lfsr", {16'd0, dut.w_lfsr_state}, 32'hACE1);
    check("seed_count", {16'd0, sample_count}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_raw(8'h64, 8'h62);
    drain();

    // Loopback with random stalls from a nonzero seed.
    @(posedge clk); #1;
    seed = 16'h1234; seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    check("load_lfsr", {16'd0, dut.w_lfsr_state}, 32'h1234);
    stall_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
      send_orig(8'($urandom_range(0, 255)));
    end
    stall_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();
    check("loop_count", {16'd0, sample_count}, 32'd1000);
    check("loop_lfsr", {16'd0, dut.w_lfsr_state}, {16'd0, m_lfsr});

    // Reset while FULL and stalled.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_orig(8'h5A);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_full_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_full_count", {16'd0, sample_count}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_raw(8'h64, 8'h62);
    check("rst_repeat_data", {24'd0, out_sample}, 32'h62);
    send_raw(8'h00, 8'hFF);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
